apb_ss_initiator: RTL and testbench
===================================

// Module: apb_ss_initiator
// PURPOSE
//  APB requester (initiator) that drives the APB slave port of a subsystem (PSEL/PENABLE/PADDR...).
//  Converts single valid/ready commands into one APB SETUP+ACCESS transfer.
//  Returns read data and error status on a valid/ready response channel.
//  Bounded wait-state timeout so a tied-off subsystem (PREADY held 0) cannot hang the bus.
// PARAMETERS
//  ADDR_W   32  APB address width
//  DATA_W   32  APB data width
//  TIMEOUT  16  max ACCESS cycles with PREADY=0 before abort; 0 = no timeout (wait forever)
// PORTS
//  clk_in       in   1       system clock, all logic on rising edge
//  reset_int    in   1       asynchronous, active-low reset
//  cmd_valid    in   1       command request
//  cmd_ready    out  1       command accepted when cmd_valid&cmd_ready
//  cmd_addr     in   ADDR_W  transfer address
//  cmd_wdata    in   DATA_W  write data
//  cmd_write    in   1       1=write, 0=read
//  rsp_valid    out  1       response available
//  rsp_ready    in   1       response consumed when rsp_valid&rsp_ready
//  rsp_rdata    out  DATA_W  read data (0 for writes and timeouts)
//  rsp_err      out  1       PSLVERR sampled, or timeout
//  rsp_timeout  out  1       transfer aborted by timeout
//  busy         out  1       state != IDLE
//  PADDR        out  ADDR_W  APB address
//  PSEL         out  1       APB select
//  PENABLE      out  1       APB enable
//  PWRITE       out  1       APB direction
//  PWDATA       out  DATA_W  APB write data
//  PRDATA       in   DATA_W  APB read data
//  PREADY       in   1       APB ready
//  PSLVERR      in   1       APB slave error
// BEHAVIOUR
//  Reset (reset_int=0, async): state IDLE; all outputs 0 (cmd_ready also 0 while reset asserted);
//   timeout counter 0; in-flight transfer or pending response discarded; no response issued.
//  All outputs except cmd_ready and busy are registered; cmd_ready=(state==IDLE), busy=(state!=IDLE).
//  FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE:
//   IDLE:   cmd_ready=1. On cmd_valid: latch addr/wdata/write into PADDR/PWDATA/PWRITE, PSEL=1, PENABLE=0 -> SETUP.
//   SETUP:  exactly one cycle; next cycle PENABLE=1 -> ACCESS. Counter cleared.
//   ACCESS: PADDR/PWRITE/PWDATA/PSEL/PENABLE stable.
//     PREADY=1: rsp_rdata=PWRITE?0:PRDATA, rsp_err=PSLVERR, rsp_timeout=0; PSEL=PENABLE=0; rsp_valid=1 -> RESP.
//     PREADY=0, TIMEOUT!=0, counter==TIMEOUT-1: abort; PSEL=PENABLE=0, rsp_rdata=0,
//       rsp_err=1, rsp_timeout=1, rsp_valid=1 -> RESP.
//     otherwise counter+1, stay. PREADY=1 on the final allowed cycle wins (normal completion).
//     Counter width $clog2(TIMEOUT+1), saturating; never wraps.
//   RESP:   rsp_valid and rsp_* held stable until rsp_ready; on handshake rsp_valid=0 -> IDLE.
//  Minimum latency: cmd handshake cycle 0, SETUP 1, ACCESS 2 (PREADY=1), rsp_valid=1 in cycle 3.
//  Throughput: one outstanding transfer; next cmd accepted in the cycle after the rsp handshake (IDLE).
//  PADDR/PWRITE/PWDATA hold last values in IDLE/RESP (no toggling); PSEL=0 there.
//  PREADY/PSLVERR/PRDATA ignored outside ACCESS. cmd_* ignored outside IDLE.
//  Timeout abort drops PSEL mid-ACCESS (intentional APB deviation, flagged via rsp_timeout).
// TESTING
//  Read, zero wait: cmd addr=0x0000_0010 read, slave PREADY=1 PRDATA=0xCAFE_F00D in ACCESS ->
//   PSEL cyc1-2, PENABLE cyc2, rsp_valid cyc3, rsp_rdata=0xCAFE_F00D, rsp_err=0.
//  Write, 3 wait states: cmd addr=0x4 wdata=0x1234_5678 write, PREADY low 3 ACCESS cycles ->
//   PWDATA/PADDR stable throughout, rsp_valid on cycle 6, rsp_rdata=0, rsp_err=0.
//  Slave error: read with PREADY=1, PSLVERR=1 -> rsp_err=1, rsp_timeout=0.
//  Timeout vs tied-off slave (PREADY=0, TIMEOUT=16): rsp_valid 16 ACCESS cycles after ACCESS entry,
//   rsp_err=1, rsp_timeout=1, PSEL=0; variant PREADY=1 on 16th cycle -> normal completion, no timeout.
//  Backpressure: rsp_ready=0 for 5 cycles -> rsp_* stable, cmd_ready=0, second cmd_valid not accepted
//   until cycle after rsp handshake.
//  Reset mid-ACCESS: reset_int low while PSEL=1 -> PSEL/PENABLE/rsp_valid 0 immediately; after release
//   IDLE, cmd_ready=1, no stale response.

Source files
------------

// File: rtl/apb_ss_initiator_if.sv
// Command, response and APB signal bundle for the APB subsystem initiator.
// Pure wiring with no logic and no added latency.
// Flow control is carried by cmd_valid/cmd_ready, rsp_valid/rsp_ready and PREADY.
interface apb_ss_initiator_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // command channel
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              cmd_write;
  // response channel
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  // APB requester port
  logic [ADDR_W-1:0] PADDR;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  // initiator side: accepts commands, returns responses, drives APB
  modport master (
    input  cmd_valid, cmd_addr, cmd_wdata, cmd_write, rsp_ready,
    input  PRDATA, PREADY, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA
  );

  // environment side: issues commands, consumes responses, acts as APB completer
  modport slave (
    output cmd_valid, cmd_addr, cmd_wdata, cmd_write, rsp_ready,
    output PRDATA, PREADY, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA
  );
endinterface

// File: rtl/apb_ss_initiator.sv
// APB initiator: one valid/ready command becomes one APB SETUP+ACCESS transfer, with a bounded wait-state timeout.
// Latency is 3 cycles from command handshake to rsp_valid when there are no wait states; one transfer is outstanding at a time.
// cmd_ready is low from acceptance until the cycle after the response handshake; rsp_* are held until rsp_ready.
module apb_ss_initiator #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic               clk_in,
  input  logic               reset_int,
  apb_ss_initiator_if.master bus,
  output logic               busy
);

  // When TIMEOUT is 0 the counter is never compared, so a single bit is kept to avoid a zero-width vector.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              pwrite_q, pwrite_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_tmo_q, rsp_tmo_d;

  // State and registered outputs; reset drops any in-flight transfer or pending response.
  always_ff @(posedge clk_in or negedge reset_int) begin
    if (!reset_int) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_tmo_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwrite_q    <= pwrite_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      rsp_tmo_q   <= rsp_tmo_d;
    end
  end

  // Next-state logic: everything holds by default, so APB address/data stay quiet in IDLE and RESP.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pwrite_d    = pwrite_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    rsp_tmo_d   = rsp_tmo_q;
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          paddr_d   = bus.cmd_addr;
          pwdata_d  = bus.cmd_wdata;
          pwrite_d  = bus.cmd_write;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = S_SETUP;
        end
      end
      S_SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = S_ACCESS;
      end
      S_ACCESS: begin
        // PREADY is checked first so a completion on the last allowed cycle beats the timeout.
        if (bus.PREADY) begin
          rsp_rdata_d = pwrite_q ? '0 : bus.PRDATA;
          rsp_err_d   = bus.PSLVERR;
          rsp_tmo_d   = 1'b0;
          rsp_valid_d = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = S_RESP;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          // Abort drops PSEL mid-ACCESS; rsp_timeout tells the requester why.
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          rsp_tmo_d   = 1'b1;
          rsp_valid_d = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = S_RESP;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // cmd_ready is gated by reset so nothing is accepted while reset is held.
  assign bus.cmd_ready   = (state_q == S_IDLE) && reset_int;
  assign busy            = (state_q != S_IDLE);
  assign bus.PADDR       = paddr_q;
  assign bus.PWDATA      = pwdata_q;
  assign bus.PWRITE      = pwrite_q;
  assign bus.PSEL        = psel_q;
  assign bus.PENABLE     = penable_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_tmo_q;

endmodule

// File: tb/tb_apb_ss_initiator.sv
// Testbench for apb_ss_initiator: per-scenario tasks drive commands and act as the APB completer.
// Expected responses and latencies come from a small model and are queued, then popped on each response.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_apb_ss_initiator;

  localparam int TMO = 16;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
    int          lat;
  } exp_t;

  logic clk_in = 1'b0;
  logic reset_int = 1'b1;
  logic busy;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb_q[$];

  apb_ss_initiator_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  apb_ss_initiator #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .clk_in   (clk_in),
    .reset_int(reset_int),
    .bus      (bus),
    .busy     (busy)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: the response and the cycle (relative to the command handshake) at which it appears.
  task automatic push_exp(input logic wr, input int waits, input logic [31:0] rd, input logic serr);
    exp_t e;
    if (waits >= TMO) begin
      e.rdata = 32'h0; e.err = 1'b1; e.tmo = 1'b1; e.lat = 2 + TMO;
    end else begin
      e.rdata = wr ? 32'h0 : rd; e.err = serr; e.tmo = 1'b0; e.lat = 3 + waits;
    end
    sb_q.push_back(e);
  endtask

  // Drives one command and plays an APB completer with 'waits' PREADY-low ACCESS cycles,
  // then holds rsp_ready low for 'hold' cycles while offering a second command.
  task automatic run_xfer(input logic [31:0] addr, input logic [31:0] wdata, input logic wr,
                          input int waits, input logic [31:0] rd, input logic serr, input int hold,
                          output int lat, output logic [31:0] rdata, output logic err,
                          output logic tmo, output logic apb_ok, output logic hold_ok,
                          output logic idle_ok);
    int cyc;
    int acc;
    int guard;
    apb_ok = 1'b1; hold_ok = 1'b1; idle_ok = 1'b1;
    lat = -1; rdata = 32'h0; err = 1'b0; tmo = 1'b0;
    guard = 0;
    while (bus.cmd_ready !== 1'b1 && guard < 50) begin
      @(negedge clk_in);
      guard++;
    end
    bus.cmd_valid = 1'b1; bus.cmd_addr = addr; bus.cmd_wdata = wdata; bus.cmd_write = wr;
    @(negedge clk_in);
    bus.cmd_valid = 1'b0; bus.cmd_addr = $urandom; bus.cmd_wdata = $urandom; bus.cmd_write = $urandom;
    cyc = 1;
    acc = 0;
    while (bus.rsp_valid !== 1'b1 && cyc < 200) begin
      if (cyc == 1) begin
        if (!(bus.PSEL === 1'b1 && bus.PENABLE === 1'b0)) apb_ok = 1'b0;
      end else if (!(bus.PSEL === 1'b1 && bus.PENABLE === 1'b1)) apb_ok = 1'b0;
      if (bus.PADDR !== addr || bus.PWRITE !== wr || (wr && bus.PWDATA !== wdata)) apb_ok = 1'b0;
      if (bus.PSEL === 1'b1 && bus.PENABLE === 1'b1) begin
        acc++;
        bus.PREADY = (acc == waits + 1); bus.PRDATA = rd; bus.PSLVERR = serr;
      end else begin
        bus.PREADY = $urandom; bus.PRDATA = $urandom; bus.PSLVERR = $urandom;
      end
      @(negedge clk_in);
      cyc++;
    end
    bus.PREADY = 1'b0; bus.PRDATA = $urandom; bus.PSLVERR = 1'b0;
    if (bus.rsp_valid === 1'b1) lat = cyc;
    rdata = bus.rsp_rdata; err = bus.rsp_err; tmo = bus.rsp_timeout;
    if (bus.PSEL !== 1'b0 || bus.PENABLE !== 1'b0 || busy !== 1'b1) apb_ok = 1'b0;
    for (int h = 0; h < hold; h++) begin
      bus.rsp_ready = 1'b0;
      bus.cmd_valid = 1'b1; bus.cmd_addr = ~addr; bus.cmd_write = 1'b0;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== rdata || bus.rsp_err !== err ||
          bus.rsp_timeout !== tmo || bus.cmd_ready !== 1'b0 || bus.PSEL !== 1'b0) hold_ok = 1'b0;
      @(negedge clk_in);
    end
    if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== rdata || bus.PSEL !== 1'b0) hold_ok = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk_in);
    bus.rsp_ready = 1'b0;
    if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1 || busy !== 1'b0) idle_ok = 1'b0;
  endtask

  task automatic test_reset();
    reset_int = 1'b1;
    #2 reset_int = 1'b0;
    repeat (2) @(negedge clk_in);
    n_cmp++;
    if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout});
    end
    n_cmp++;
    if ({bus.PADDR, bus.PWDATA, bus.rsp_rdata} !== 96'h0) begin
      n_bad++;
      $display("FAIL reset_data: got %h %h %h expected zeros", bus.PADDR, bus.PWDATA, bus.rsp_rdata);
    end
    n_cmp++;
    if (bus.cmd_ready !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ready: got cmd_ready=%b busy=%b expected 0 0", bus.cmd_ready, busy);
    end
    reset_int = 1'b1;
    @(negedge clk_in);
    n_cmp++;
    if (bus.cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL post_reset_idle: got cmd_ready=%b busy=%b expected 1 0", bus.cmd_ready, busy);
    end
  endtask

  // Shared shape for scenario tasks: push expectation, run, pop and compare inline.
  task automatic test_read_zero_wait();
    int lat; logic [31:0] rdata; logic err, tmo, apb_ok, hold_ok, idle_ok; exp_t e;
    push_exp(1'b0, 0, 32'hCAFE_F00D, 1'b0);
    run_xfer(32'h0000_0010, 32'h0, 1'b0, 0, 32'hCAFE_F00D, 1'b0, 0,
             lat, rdata, err, tmo, apb_ok, hold_ok, idle_ok);
    e = sb_q.pop_front();
    n_cmp++;
    if (rdata !== e.rdata || err !== e.err || tmo !== e.tmo) begin
      n_bad++;
      $display("FAIL read0_rsp: got %h/%b/%b expected %h/%b/%b", rdata, err, tmo, e.rdata, e.err, e.tmo);
    end
    n_cmp++;
    if (lat !== e.lat) begin n_bad++; $display("FAIL read0_latency: got %0d expected %0d", lat, e.lat); end
    n_cmp++;
    if (apb_ok !== 1'b1 || idle_ok !== 1'b1) begin
      n_bad++; $display("FAIL read0_apb_phases: got apb=%b idle=%b expected 1 1", apb_ok, idle_ok);
    end
  endtask

  task automatic test_write_waits();
    int lat; logic [31:0] rdata; logic err, tmo, apb_ok, hold_ok, idle_ok; exp_t e;
    push_exp(1'b1, 3, 32'hDEAD_BEEF, 1'b0);
    run_xfer(32'h0000_0004, 32'h1234_5678, 1'b1, 3, 32'hDEAD_BEEF, 1'b0, 0,
             lat, rdata, err, tmo, apb_ok, hold_ok, idle_ok);
    e = sb_q.pop_front();
    n_cmp++;
    if (rdata !== e.rdata || err !== e.err || tmo !== e.tmo) begin
      n_bad++;
      $display("FAIL write3_rsp: got %h/%b/%b expected %h/%b/%b", rdata, err, tmo, e.rdata, e.err, e.tmo);
    end
    n_cmp++;
    if (lat !== e.lat) begin n_bad++; $display("FAIL write3_latency: got %0d expected %0d", lat, e.lat); end
    n_cmp++;
    if (apb_ok !== 1'b1) begin n_bad++; $display("FAIL write3_apb_stable: got %b expected 1", apb_ok); end
  endtask

  task automatic test_slave_error();
    int lat; logic [31:0] rdata; logic err, tmo, apb_ok, hold_ok, idle_ok; exp_t e;
    push_exp(1'b0, 1, 32'h5A5A_0001, 1'b1);
    run_xfer(32'h0000_0020, 32'h0, 1'b0, 1, 32'h5A5A_0001, 1'b1, 0,
             lat, rdata, err, tmo, apb_ok, hold_ok, idle_ok);
    e = sb_q.pop_front();
    n_cmp++;
    if (err !== e.err || tmo !== e.tmo || rdata !== e.rdata) begin
      n_bad++;
      $display("FAIL slverr_rsp: got %h/%b/%b expected %h/%b/%b", rdata, err, tmo, e.rdata, e.err, e.tmo);
    end
  endtask

  task automatic test_timeout();
    int waits_tab[2] = '{100, TMO - 1};
    int lat; logic [31:0] rdata; logic err, tmo, apb_ok, hold_ok, idle_ok; exp_t e;
    for (int i = 0; i < 2; i++) begin
      push_exp(1'b0, waits_tab[i], 32'h7777_0000 + i, 1'b0);
      run_xfer(32'h0000_0100 + i, 32'h0, 1'b0, waits_tab[i], 32'h7777_0000 + i, 1'b0, 0,
               lat, rdata, err, tmo, apb_ok, hold_ok, idle_ok);
      e = sb_q.pop_front();
      n_cmp++;
      if (rdata !== e.rdata || err !== e.err || tmo !== e.tmo) begin
        n_bad++;
        $display("FAIL timeout_rsp[%0d]: got %h/%b/%b expected %h/%b/%b",
                 i, rdata, err, tmo, e.rdata, e.err, e.tmo);
      end
      n_cmp++;
      if (lat !== e.lat) begin
        n_bad++; $display("FAIL timeout_latency[%0d]: got %0d expected %0d", i, lat, e.lat);
      end
      n_cmp++;
      if (apb_ok !== 1'b1 || idle_ok !== 1'b1) begin
        n_bad++; $display("FAIL timeout_psel[%0d]: got apb=%b idle=%b expected 1 1", i, apb_ok, idle_ok);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat; logic [31:0] rdata; logic err, tmo, apb_ok, hold_ok, idle_ok; exp_t e;
    push_exp(1'b0, 2, 32'hB00B_1E55, 1'b0);
    run_xfer(32'h0000_0200, 32'h0, 1'b0, 2, 32'hB00B_1E55, 1'b0, 5,
             lat, rdata, err, tmo, apb_ok, hold_ok, idle_ok);
    e = sb_q.pop_front();
    n_cmp++;
    if (rdata !== e.rdata || lat !== e.lat) begin
      n_bad++; $display("FAIL bp_rsp: got %h lat %0d expected %h lat %0d", rdata, lat, e.rdata, e.lat);
    end
    n_cmp++;
    if (hold_ok !== 1'b1) begin n_bad++; $display("FAIL bp_hold_stable: got %b expected 1", hold_ok); end
    n_cmp++;
    if (idle_ok !== 1'b1) begin n_bad++; $display("FAIL bp_ready_after: got %b expected 1", idle_ok); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] rdata; logic err, tmo, apb_ok, hold_ok, idle_ok; exp_t e;
    logic [31:0] a, wd, rd; logic wr, se; int w, h;
    for (int i = 0; i < 6; i++) begin
      a = $urandom; wd = $urandom; rd = $urandom; wr = $urandom; se = $urandom;
      w = $urandom_range(0, 5); h = $urandom_range(0, 2);
      push_exp(wr, w, rd, se);
      run_xfer(a, wd, wr, w, rd, se, h, lat, rdata, err, tmo, apb_ok, hold_ok, idle_ok);
      e = sb_q.pop_front();
      n_cmp++;
      if (rdata !== e.rdata || err !== e.err || tmo !== e.tmo || lat !== e.lat) begin
        n_bad++;
        $display("FAIL b2b_rsp[%0d]: got %h/%b/%b lat %0d expected %h/%b/%b lat %0d",
                 i, rdata, err, tmo, lat, e.rdata, e.err, e.tmo, e.lat);
      end
      n_cmp++;
      if (apb_ok !== 1'b1 || hold_ok !== 1'b1 || idle_ok !== 1'b1) begin
        n_bad++;
        $display("FAIL b2b_proto[%0d]: got %b%b%b expected 111", i, apb_ok, hold_ok, idle_ok);
      end
    end
  endtask

  task automatic test_reset_mid_access();
    int guard;
    int seen;
    bus.cmd_valid = 1'b1; bus.cmd_addr = 32'h0000_0300; bus.cmd_write = 1'b0; bus.PREADY = 1'b0;
    @(negedge clk_in);
    bus.cmd_valid = 1'b0;
    guard = 0;
    while (bus.PENABLE !== 1'b1 && guard < 20) begin
      @(negedge clk_in);
      guard++;
    end
    n_cmp++;
    if (bus.PSEL !== 1'b1 || bus.PENABLE !== 1'b1) begin
      n_bad++; $display("FAIL rst_mid_reach_access: got PSEL=%b PENABLE=%b expected 1 1", bus.PSEL, bus.PENABLE);
    end
    #2 reset_int = 1'b0;
    #1;
    n_cmp++;
    if (bus.PSEL !== 1'b0 || bus.PENABLE !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid_async: got %b%b%b%b expected 0000",
               bus.PSEL, bus.PENABLE, bus.rsp_valid, bus.cmd_ready);
    end
    @(negedge clk_in);
    reset_int = 1'b1;
    bus.PREADY = 1'b1;
    @(negedge clk_in);
    n_cmp++;
    if (bus.cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL rst_mid_idle: got cmd_ready=%b busy=%b expected 1 0", bus.cmd_ready, busy);
    end
    bus.rsp_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_in);
      if (bus.rsp_valid === 1'b1 || bus.PSEL === 1'b1) seen++;
    end
    bus.rsp_ready = 1'b0; bus.PREADY = 1'b0;
    n_cmp++;
    if (seen !== 0 || sb_q.size() !== 0) begin
      n_bad++; $display("FAIL rst_mid_stale: got %0d active cycles, %0d queued expected 0 0", seen, sb_q.size());
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0; bus.cmd_write = 1'b0;
    bus.rsp_ready = 1'b0; bus.PRDATA = '0; bus.PREADY = 1'b0; bus.PSLVERR = 1'b0;
    test_reset();
    test_read_zero_wait();
    test_write_waits();
    test_slave_error();
    test_timeout();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_access();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
